scan_test_ctrl: RTL and testbench
=================================

# scan_test_ctrl

Sequencer for a single scan chain built from scan flip-flops (clk, reset, scan_en, scan_in, d, q, scan_out cells connected head-to-tail). On a start request it serially loads a test pattern into the chain, pulses one functional capture cycle, then unloads the captured response while comparing it against an expected vector. It sits between the test-access logic (pattern source, result sink) and the chain, and owns `scan_en` and `scan_in` for that chain.

## Interface
- `CHAIN_LEN`, default 8: number of cells in the chain, must be ≥ 2.
- `CNT_W`, default `$clog2(CHAIN_LEN)`: width of the bit counter.

- `clk`  in  1  rising-edge clock shared with the chain.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one load/capture/unload test; sampled in IDLE only.
- `pattern`  in  CHAIN_LEN  stimulus; bit i ends up in chain cell i (cell 0 = head).
- `expected`  in  CHAIN_LEN  golden capture value; bit i compared with cell i.
- `chain_out`  in  1  `scan_out` of the tail cell (cell CHAIN_LEN-1).
- `scan_en`  out  1  to all cells: 1 = shift, 0 = functional capture.
- `scan_in`  out  1  to head cell.
- `busy`  out  1  high from the cycle after start acceptance until `done`.
- `done`  out  1  one-cycle pulse when a test completes.
- `pass`  out  1  valid with `done`, held until next acceptance: captured == expected.
- `captured`  out  CHAIN_LEN  unloaded response, held until next acceptance.

## Operation
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: `scan_en`=0, `scan_in`=0, `busy`=0. `start`=1 registers `pattern`/`expected`, clears counter → SHIFT_IN.
- SHIFT_IN: `scan_en`=1; cycle k (k=0..CHAIN_LEN-1) drives `scan_in`=pattern[CHAIN_LEN-1-k]. After CHAIN_LEN shifting edges cell i holds pattern[i]. Counter at CHAIN_LEN-1 → CAPTURE.
- CAPTURE: exactly one cycle, `scan_en`=0, `scan_in`=0; chain loads its `d` inputs → SHIFT_OUT.
- SHIFT_OUT: `scan_en`=1, `scan_in`=0; in cycle k the controller samples `chain_out` on the rising edge into captured[CHAIN_LEN-1-k]. Counter at CHAIN_LEN-1 → DONE.
- DONE: `done`=1, `pass`=(captured == expected), `busy`=0 → IDLE.
- `start` outside IDLE is ignored (no queueing). `start` held high in DONE's following IDLE cycle launches a new test (back-to-back allowed).
- Comparison is full-width equality; no masking.

## Timing
- All outputs registered; reset values: `scan_en`=0, `scan_in`=0, `busy`=0, `done`=0, `pass`=0, `captured`=0, state IDLE, counter 0.
- Start accepted at edge E0; `scan_en` rises at E0; first `scan_in` bit valid after E0.
- Shifting edges E1..E_N (N=CHAIN_LEN); capture edge E_{N+1}; unload sample edges E_{N+2}..E_{2N+1}; `done` high in cycle after E_{2N+1}, i.e. latency 2N+2 edges from acceptance to `done` (18 for N=8).
- `chain_out` is the tail flop's q; sampling at the same edge that shifts is correct because the controller captures pre-edge value.
- Reset asserted mid-test: immediate return to IDLE, `scan_en`=0, results cleared; chain contents undefined, no `done`.
- Counter wraps only through state transitions; it never exceeds CHAIN_LEN-1.

## Structure
- Package `scan_ctrl_pkg`: state enum `scan_state_t` (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE) and state-width constant.
- Single module; no sub-module needed in RTL. Bench wrapper `scan_chain` instantiates CHAIN_LEN scan flip-flops head-to-tail with a CHAIN_LEN-bit `d` bus.

## Test plan
- N=8, pattern 8'hA5, chain `d` tied 8'h3C, expected 8'h3C → after 18 cycles `done` pulse, `pass`=1, `captured`=8'h3C; chain held 8'hA5 at CAPTURE edge (probe).
- Same, expected 8'h3D → `pass`=0, `captured`=8'h3C.
- `d` tied 8'h00 then 8'hFF, expected equal → `pass`=1 both; checks all-zero/all-one unload ordering.
- `start` pulsed during SHIFT_IN and SHIFT_OUT → ignored; exactly one `done`, latency unchanged.
- `reset` low during SHIFT_OUT cycle 3 → outputs at reset values next sample, no `done`; new start after release completes normally with `pass`=1.
- `start` held high continuously → consecutive tests, `done` every 19 cycles, `scan_en` low in CAPTURE and IDLE cycles only.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding for the single-chain scan test sequencer.
package scan_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_chain.sv
// Chain of CHAIN_LEN mux-D scan flops, cell 0 at the head; shift when scan_en else load d.
// One cycle per shift/capture; no backpressure.
module scan_chain #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en,
  input  logic                 scan_in,
  input  logic [CHAIN_LEN-1:0] d,
  output logic [CHAIN_LEN-1:0] q,
  output logic                 scan_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (scan_en) begin
      q <= {q[CHAIN_LEN-2:0], scan_in};
    end else begin
      q <= d;
    end
  end

  assign scan_out = q[CHAIN_LEN-1];

endmodule

// File: rtl/scan_test_ctrl.sv
// Load/capture/unload sequencer for one scan chain; done 2*CHAIN_LEN+1 edges after the accept edge.
// start is only honoured in IDLE; requests while busy are dropped, never queued.
module scan_test_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 chain_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 scan_en_d, scan_in_d, busy_d, done_d, pass_d;
  logic [CHAIN_LEN-1:0] captured_d;
  logic [CNT_W-1:0]     cnt_inc, nxt_idx, cur_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      scan_en  <= 1'b0;
      scan_in  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      exp_q    <= exp_d;
      scan_en  <= scan_en_d;
      scan_in  <= scan_in_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      captured <= captured_d;
    end
  end

  // Outputs are registered, so each branch computes what the next cycle drives.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    scan_en_d  = scan_en;
    scan_in_d  = scan_in;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    captured_d = captured;
    cnt_inc    = cnt_q + 1'b1;
    nxt_idx    = LAST - cnt_inc;
    cur_idx    = LAST - cnt_q;

    unique case (state_q)
      IDLE: begin
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          state_d    = SHIFT_IN;
          pat_d      = pattern;
          exp_d      = expected;
          cnt_d      = '0;
          scan_en_d  = 1'b1;
          scan_in_d  = pattern[CHAIN_LEN-1];
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          captured_d = '0;
        end
      end

      SHIFT_IN: begin
        if (cnt_q == LAST) begin
          state_d   = CAPTURE;
          cnt_d     = '0;
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
        end else begin
          cnt_d     = cnt_inc;
          scan_in_d = pat_q[nxt_idx];
        end
      end

      CAPTURE: begin
        state_d   = SHIFT_OUT;
        cnt_d     = '0;
        scan_en_d = 1'b1;
        scan_in_d = 1'b0;
      end

      SHIFT_OUT: begin
        // chain_out is the tail q before this edge shifts, so it is the bit for cur_idx.
        captured_d[cur_idx] = chain_out;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (captured_d == exp_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        // scan_en stays high through DONE; the chain is don't-care once unloaded.
        state_d   = IDLE;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl driving a real scan_chain; expectations come from a per-cycle schedule of the test.
module tb_scan_test_ctrl;

  localparam int N      = 8;
  localparam int PERIOD = 2 * N + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] pattern, expected, chain_d, chain_q, captured;
  logic         chain_out, scan_en, scan_in, busy, done, pass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .expected(expected),
    .chain_out(chain_out), .scan_en(scan_en), .scan_in(scan_in), .busy(busy),
    .done(done), .pass(pass), .captured(captured)
  );

  scan_chain #(.CHAIN_LEN(N)) chain (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in),
    .d(chain_d), .q(chain_q), .scan_out(chain_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full test; the schedule is indexed by t = cycles since the accept edge.
  task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] dv,
                          input logic [N-1:0] ev, input bit poke);
    @(negedge clk);
    pattern  = pat;
    expected = ev;
    chain_d  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= 2 * N + 1; t++) begin
      if (t > 0) @(negedge clk);
      chk("scan_en", scan_en, (t != N));
      chk("scan_in", scan_in, (t < N) ? pat[N-1-t] : 1'b0);
      chk("busy", busy, (t <= 2 * N));
      chk("done", done, (t == 2 * N + 1));
      if (t == N) chk("chain_at_capture", chain_q, pat);
      if (t == 2 * N + 1) begin
        chk("pass", pass, (dv == ev));
        chk("captured", captured, dv);
      end
      if (t == 1) begin
        pattern  = ~pat;
        expected = ~ev;
      end
      start = poke && (t == 2 || t == N + 4);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 1'b0);
    chk("idle_scan_en", scan_en, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("held_pass", pass, (dv == ev));
    chk("held_captured", captured, dv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] p, dv, ev;
    int           done_cnt;
    int           t;

    reset    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    expected = '0;
    chain_d  = '0;
    #3;
    chk("rst_scan_en", scan_en, 1'b0);
    chk("rst_scan_in", scan_in, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_captured", captured, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_test(8'hA5, 8'h3C, 8'h3C, 1'b0);
    run_test(8'hA5, 8'h3C, 8'h3D, 1'b0);
    p = N'($urandom);
    run_test(p, 8'h00, 8'h00, 1'b0);
    p = N'($urandom);
    run_test(p, 8'hFF, 8'hFF, 1'b0);
    run_test(8'hA5, 8'h3C, 8'h3C, 1'b1);

    // Randomized cases: expected matches or differs by one bit
    for (int i = 0; i < 8; i++) begin
      p  = N'($urandom);
      dv = N'($urandom);
      ev = dv;
      if ($urandom_range(0, 1) == 1) ev[$urandom_range(0, N - 1)] ^= 1'b1;
      run_test(p, dv, ev, 1'b0);
    end

    // Reset during SHIFT_OUT cycle 3
    @(negedge clk);
    pattern  = N'($urandom);
    chain_d  = 8'h5A;
    expected = 8'h5A;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    chk("busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_scan_en", scan_en, 1'b0);
    chk("midrst_scan_in", scan_in, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    chk("midrst_captured", captured, '0);
    reset = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < PERIOD; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_reset", done_cnt, 0);
    run_test(8'hC3, 8'h96, 8'h96, 1'b0);

    // start held high: back-to-back tests
    @(negedge clk);
    pattern  = N'($urandom);
    chain_d  = 8'h71;
    expected = 8'h71;
    start    = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      @(negedge clk);
      t = c % PERIOD;
      chk("b2b_done", done, (t == 2 * N + 1));
      chk("b2b_scan_en", scan_en, !(t == N || t == 2 * N + 2));
      if (t == 2 * N + 1) chk("b2b_pass", pass, 1'b1);
      if (done) done_cnt++;
    end
    start = 1'b0;
    chk("b2b_done_count", done_cnt, 3);
    repeat (PERIOD) @(negedge clk);
    chk("b2b_final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
